// File: rtl/soc_rst_pkg.sv
// Shared types and constants for the SoC reset sequencer.
package soc_rst_pkg;

  typedef enum logic [1:0] {
    POR_HOLD,
    TAP_REL,
    RUN,
    NDM
  } rst_state_e;

  localparam logic CAUSE_POR = 1'b0;
  localparam logic CAUSE_NDM = 1'b1;

  localparam int NDM_COUNT_W = 8;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/soc_reset_sequencer_rst_down_counter.sv
// Loadable down-counter with a zero flag; it stops at zero rather than wrapping.
module rst_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/soc_reset_sequencer.sv
// Orders TAP reset release, system reset release and JTAG bridge enable after
// power-on, and services debug ndmreset requests by pulsing system reset only.
module soc_reset_sequencer
  import soc_rst_pkg::*;
#(
  parameter int TRST_CYCLES    = 2,
  parameter int SYS_CYCLES     = 4,
  parameter int JTAG_DELAY     = 10,
  parameter int NDM_MIN_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ndmreset_i,
  output logic                   sys_rst_n_o,
  output logic                   trst_n_o,
  output logic                   jtag_en_o,
  output logic                   ready_o,
  output logic                   cause_o,
  output logic [NDM_COUNT_W-1:0] ndm_count_o
);

  localparam int CW = $clog2(max4(TRST_CYCLES, SYS_CYCLES, JTAG_DELAY, NDM_MIN_CYCLES)) + 1;

  if (TRST_CYCLES < 1 || SYS_CYCLES < 1 || JTAG_DELAY < 1 || NDM_MIN_CYCLES < 1) begin : g_bad_params
    $error("soc_reset_sequencer: all cycle parameters must be >= 1");
  end

  rst_state_e             state_reg, state_next;
  logic                   rst_q_reg;
  logic                   init;
  logic                   tmr_load, tmr_dec, tmr_zero;
  logic [CW-1:0]          tmr_val;
  logic                   en_load, en_dec, en_zero, en_start;
  logic                   en_started_reg, en_started_next;
  logic                   jtag_en_reg, jtag_en_next;
  logic                   cause_reg, cause_next;
  logic [NDM_COUNT_W-1:0] ndm_count_reg, ndm_count_next;
  logic                   sys_rst_n_reg, trst_n_reg, ready_reg;

  // rst is stretched by one edge so the POR hold is counted from the first
  // full cycle after reset has gone away.
  assign init = rst | rst_q_reg;

  rst_down_counter #(.W(CW)) u_state_timer (
    .clk      (clk),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  rst_down_counter #(.W(CW)) u_enable_timer (
    .clk      (clk),
    .load     (en_load),
    .load_val (CW'(JTAG_DELAY - 1)),
    .dec      (en_dec),
    .zero     (en_zero)
  );

  always_comb begin
    state_next     = state_reg;
    tmr_load       = 1'b0;
    tmr_dec        = 1'b0;
    tmr_val        = CW'(SYS_CYCLES - 1);
    cause_next     = cause_reg;
    ndm_count_next = ndm_count_reg;
    en_start       = 1'b0;

    case (state_reg)
      POR_HOLD: begin
        if (tmr_zero) begin
          state_next = TAP_REL;
          tmr_load   = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      TAP_REL: begin
        if (ndmreset_i) begin
          tmr_load = 1'b1;
        end else if (tmr_zero) begin
          state_next = RUN;
          en_start   = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      RUN: begin
        if (ndmreset_i) begin
          state_next = NDM;
          tmr_load   = 1'b1;
          tmr_val    = CW'(NDM_MIN_CYCLES - 1);
          cause_next = CAUSE_NDM;
          if (ndm_count_reg != '1) ndm_count_next = ndm_count_reg + NDM_COUNT_W'(1);
        end
      end
      NDM: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else if (!ndmreset_i) begin
          state_next = RUN;
        end
      end
      default: state_next = POR_HOLD;
    endcase

    if (init) begin
      tmr_load = 1'b1;
      tmr_val  = CW'(TRST_CYCLES - 1);
    end
  end

  // The enable timer only ever starts from TAP_REL, so ndmreset cycles leave it alone.
  assign en_load         = init | en_start;
  assign en_dec          = en_started_reg & ~jtag_en_reg;
  assign en_started_next = en_started_reg | en_start;
  assign jtag_en_next    = jtag_en_reg | (en_started_reg & en_zero);

  always_ff @(posedge clk) begin
    rst_q_reg <= rst;
    if (init) begin
      state_reg      <= POR_HOLD;
      en_started_reg <= 1'b0;
      jtag_en_reg    <= 1'b0;
      cause_reg      <= CAUSE_POR;
      ndm_count_reg  <= '0;
      sys_rst_n_reg  <= 1'b0;
      trst_n_reg     <= 1'b0;
      ready_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      en_started_reg <= en_started_next;
      jtag_en_reg    <= jtag_en_next;
      cause_reg      <= cause_next;
      ndm_count_reg  <= ndm_count_next;
      sys_rst_n_reg  <= (state_next == RUN);
      trst_n_reg     <= (state_next != POR_HOLD);
      ready_reg      <= (state_next == RUN);
    end
  end

  assign sys_rst_n_o = sys_rst_n_reg;
  assign trst_n_o    = trst_n_reg;
  assign jtag_en_o   = jtag_en_reg;
  assign ready_o     = ready_reg;
  assign cause_o     = cause_reg;
  assign ndm_count_o = ndm_count_reg;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Scoreboard bench: the driver pushes expected outputs from a timeline model,
// the monitor pops and compares one entry per clock.
module tb_soc_reset_sequencer;

  localparam int TRST = 2;
  localparam int SYS  = 4;
  localparam int JTAG = 10;
  localparam int NDMC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ndmreset_i = 1'b0;
  logic       sys_rst_n_o, trst_n_o, jtag_en_o, ready_o, cause_o;
  logic [7:0] ndm_count_o;

  typedef struct packed {
    logic       sys;
    logic       trst;
    logic       jtag;
    logic       ready;
    logic       cause;
    logic [7:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   txn = 0;

  // Timeline model: k is the edge offset from the first edge sampling rst=0.
  int k = -1;
  bit released = 0;
  bit in_ndm = 0;
  int release_at = TRST + SYS;
  int jtag_at = 0;
  int ndm_start = 0;
  bit m_cause = 0;
  int m_count = 0;

  soc_reset_sequencer #(
    .TRST_CYCLES    (TRST),
    .SYS_CYCLES     (SYS),
    .JTAG_DELAY     (JTAG),
    .NDM_MIN_CYCLES (NDMC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ndmreset_i  (ndmreset_i),
    .sys_rst_n_o (sys_rst_n_o),
    .trst_n_o    (trst_n_o),
    .jtag_en_o   (jtag_en_o),
    .ready_o     (ready_o),
    .cause_o     (cause_o),
    .ndm_count_o (ndm_count_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t model_step(input bit r, input bit n);
    exp_t e;
    e = '0;
    if (r) begin
      k = -1; released = 0; in_ndm = 0; m_cause = 0; m_count = 0;
      release_at = TRST + SYS; jtag_at = 0;
      return e;
    end
    k++;
    if (!released) begin
      // Each ndmreset edge seen after TAP release pushes system release SYS edges out.
      if (n && k > TRST && k + SYS > release_at) release_at = k + SYS;
      if (k == release_at) begin
        released = 1;
        jtag_at = k + JTAG;
      end
    end else if (in_ndm) begin
      if (!n && k >= ndm_start + NDMC) in_ndm = 0;
    end else if (n) begin
      in_ndm = 1;
      ndm_start = k;
      m_cause = 1;
      if (m_count < 255) m_count++;
    end
    e.trst  = (k >= TRST);
    e.sys   = released && !in_ndm;
    e.ready = released && !in_ndm;
    e.jtag  = released && (k >= jtag_at);
    e.cause = m_cause;
    e.count = 8'(m_count);
    return e;
  endfunction

  task automatic step(input bit r, input bit n);
    @(negedge clk);
    rst = r;
    ndmreset_i = n;
    exp_q.push_back(model_step(r, n));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0);
  endtask

  task automatic do_reset(input int cycles);
    txn++;
    $display("txn %0d: rst for %0d cycles", txn, cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b0);
  endtask

  task automatic ndm_req(input int cycles);
    txn++;
    $display("txn %0d: ndmreset_i high for %0d cycles", txn, cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b1);
  endtask

  initial begin : monitor
    exp_t e, got;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {sys_rst_n_o, trst_n_o, jtag_en_o, ready_o, cause_o, ndm_count_o};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL outputs @%0t: got sys=%b trst=%b jtag=%b rdy=%b cause=%b cnt=%0d, expected sys=%b trst=%b jtag=%b rdy=%b cause=%b cnt=%0d",
                   $time, got.sys, got.trst, got.jtag, got.ready, got.cause, got.count,
                   e.sys, e.trst, e.jtag, e.ready, e.cause, e.count);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int kind, len;
    // Power-on sequence, single pulse, long request.
    do_reset(3);
    idle(20);
    ndm_req(1);
    idle(8);
    ndm_req(10);
    idle(8);
    // ndmreset while the system is still held in TAP_REL.
    do_reset(3);
    idle(3);
    ndm_req(5);
    idle(25);
    // NDM before the JTAG enable fires.
    do_reset(3);
    idle(8);
    ndm_req(1);
    idle(12);
    // Count saturation, then rst in the middle of an NDM.
    for (int i = 0; i < 300; i++) begin
      ndm_req(1);
      idle(5);
    end
    ndm_req(2);
    do_reset(1);
    idle(20);
    // Random mix of requests, idles and occasional resets, including back-to-back.
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 19));
      if (kind == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else if (kind < 12) begin
        ndm_req(int'($urandom_range(1, 12)));
      end else begin
        len = int'($urandom_range(0, 15));
        txn++;
        $display("txn %0d: idle for %0d cycles", txn, len);
        idle(len);
      end
    end
    idle(20);
    @(posedge clk);
    #3;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
